// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions: instruction width, opcode encodings seen by the
// control unit on dec_instr[31:26], and the canonical no-op word.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int INSTR_W = 32;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OPC_RTYPE  = 6'b110000;
    localparam opcode_t OPC_LW     = 6'b110001;
    localparam opcode_t OPC_SW     = 6'b110010;
    localparam opcode_t OPC_BEQ    = 6'b110011;
    localparam opcode_t OPC_BNE    = 6'b110100;
    localparam opcode_t OPC_ADDI   = 6'b110101;
    localparam opcode_t OPC_J      = 6'b110110;
    localparam opcode_t OPC_JAL    = 6'b110111;
    localparam opcode_t OPC_JALFOR = 6'b111000;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    // Opcode field of an instruction word.
    function automatic opcode_t opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO with synchronous clear, used by the fetch unit for
// both the instruction queue and the in-flight request-address FIFO.
// Ports:
//   clk, rst         clock, synchronous active-high reset (also zeroes storage)
//   clr              synchronous clear of pointers/count (storage untouched)
//   push, push_data  write one entry; ignored when full unless popping too
//   pop              remove the head entry; ignored when empty
//   head             current head entry (read straight from storage registers)
//   empty            no entries held
//   count            number of entries held (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int   DEPTH = 2,
    parameter int   WIDTH = 32,
    localparam int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointer advance that wraps at DEPTH, so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Instruction fetch stage: owns the PC, issues word fetches to instruction
// memory (up to MAX_OUT in flight), buffers returned words in a MAX_OUT-deep
// queue and hands them to decode over valid/ready. A redirect from a taken
// branch/jump flushes the queue and discards responses still in flight.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr fetch request channel (word aligned)
//   imem_rsp_valid, imem_rsp_data   in-order response channel
//   redirect_valid, redirect_pc     taken branch/jump target (1-cycle pulse)
//   dec_valid/ready                 decode handshake
//   dec_instr, dec_pc, dec_pc_plus4 head instruction, its address, link value
//   misalign                        1-cycle pulse for a misaligned redirect
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_OUT  = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                dec_valid,
    input  logic                dec_ready,
    output logic [INSTR_W-1:0]  dec_instr,
    output logic [ADDR_W-1:0]   dec_pc,
    output logic [ADDR_W-1:0]   dec_pc_plus4,
    output logic                misalign
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int Q_W   = INSTR_W + ADDR_W;

    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  drop_cnt;

    logic [CNT_W-1:0]  out_cnt;     // requests accepted but not yet answered
    logic [CNT_W-1:0]  q_cnt;
    logic              addr_empty;
    logic              q_empty;
    logic [ADDR_W-1:0] rsp_pc;
    logic [Q_W-1:0]    q_head;

    logic              pop;
    logic              accept;
    logic              rsp_ok;
    logic              keep;
    logic [CNT_W:0]    in_use;

    // Credit: every accepted request must own a queue slot when it returns.
    // A slot freed by this cycle's decode pop is already reusable, which is
    // what sustains one instruction per cycle with a 1-cycle memory.
    assign pop            = !q_empty && dec_ready;
    assign in_use         = {1'b0, out_cnt} + {1'b0, q_cnt} - (CNT_W + 1)'(pop);
    assign imem_req_valid = !rst && !redirect_valid && (in_use < (CNT_W + 1)'(MAX_OUT));
    assign imem_addr      = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response with nothing in flight cannot belong to us (e.g. a request
    // from before reset); ignore it.
    assign rsp_ok = imem_rsp_valid && !addr_empty;
    assign keep   = rsp_ok && (drop_cnt == '0) && !redirect_valid;

    // Address of every accepted request, so a returning word can be tagged
    // with its pc; its occupancy is the outstanding-request count.
    fetch_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (ADDR_W)
    ) u_addr_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .push      (accept),
        .push_data (pc),
        .pop       (rsp_ok),
        .head      (rsp_pc),
        .empty     (addr_empty),
        .count     (out_cnt)
    );

    // Instruction queue presented to decode; flushed on redirect.
    fetch_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (Q_W)
    ) u_instr_q (
        .clk       (clk),
        .rst       (rst),
        .clr       (redirect_valid),
        .push      (keep),
        .push_data ({imem_rsp_data, rsp_pc}),
        .pop       (pop),
        .head      (q_head),
        .empty     (q_empty),
        .count     (q_cnt)
    );

    assign dec_valid    = !q_empty;
    assign dec_instr    = q_head[ADDR_W +: INSTR_W];
    assign dec_pc       = q_head[ADDR_W-1:0];
    assign dec_pc_plus4 = dec_pc + ADDR_W'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            drop_cnt <= '0;
            misalign <= 1'b0;
        end else begin
            misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                pc       <= {redirect_pc[ADDR_W-1:2], 2'b00};
                // Everything still in flight after this cycle is stale; a
                // response landing in this very cycle is already discarded.
                drop_cnt <= out_cnt - CNT_W'(rsp_ok);
            end else begin
                if (accept) begin
                    pc <= pc + ADDR_W'(4);
                end
                if (rsp_ok && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          MAX_OUT  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus4;
    logic        misalign;

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .MAX_OUT  (MAX_OUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_pc_plus4   (dec_pc_plus4),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Memory contents: a bijective scramble of the address, so every word is
    // distinct and a word delivered with the wrong pc is caught.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rsv;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        drdy;
        logic        chk;      // compare dec_pc/dec_instr even with dec_valid=0
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_dv;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    localparam logic [31:0] W0  = 32'hC400_0000;
    localparam logic [31:0] W4  = 32'hC800_0004;
    localparam logic [31:0] W8  = 32'hD400_0008;
    localparam logic [31:0] W12 = 32'hD800_000C;
    localparam logic [31:0] WA  = 32'hDC00_0100;
    localparam logic [31:0] WB  = 32'hC000_0000;

    vec_t tbl [18];

    // ---------------- reference model state ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend [$];       // requests accepted by memory, in order
    logic [31:0] exp_pc;         // next pc decode must receive
    logic [31:0] exp_fetch;      // next address the fetch unit must request
    logic        exp_mis = 1'b0;
    int          delivered = 0;
    int          accepts = 0;
    int          cyc = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          rsp_pct = 100;
    logic        last_rv;
    logic        last_dv;
    logic [31:0] last_hs_pc;

    // One clock cycle against the memory model and the architectural model.
    task automatic tick(input logic r, input logic rdy_i, input logic dr_i,
                        input logic redir_i, input logic [31:0] rpc_i);
        @(negedge clk);
        rst = r;
        if (!r && pend.size() > 0 && cyc >= pend[0].due && $urandom_range(99) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = rdy_i;
        dec_ready      = dr_i;
        redirect_valid = redir_i;
        redirect_pc    = rpc_i;
        #1;
        last_rv = imem_req_valid;
        last_dv = dec_valid;
        check("misalign", {31'b0, misalign}, {31'b0, exp_mis});
        if (r || redir_i)
            check("req_valid_blocked", {31'b0, imem_req_valid}, 32'd0);
        if (dec_valid)
            check("dec_pc_plus4", dec_pc_plus4, dec_pc + 32'd4);
        if (dec_valid && dr_i) begin
            check("dec_pc", dec_pc, exp_pc);
            check("dec_instr", dec_instr, mem_word(exp_pc));
            last_hs_pc = dec_pc;
            exp_pc     = exp_pc + 32'd4;
            delivered++;
        end
        if (imem_req_valid && rdy_i) begin
            check("imem_addr", imem_addr, exp_fetch);
            check("outstanding_bound", {31'b0, pend.size() < MAX_OUT}, 32'd1);
            pend.push_back('{imem_addr, cyc + int'($urandom_range(lat_hi, lat_lo))});
            exp_fetch = exp_fetch + 32'd4;
            accepts++;
        end
        if (r) begin
            exp_pc    = RESET_PC;
            exp_fetch = RESET_PC;
            exp_mis   = 1'b0;
            pend.delete();
        end else if (redir_i) begin
            exp_pc    = {rpc_i[31:2], 2'b00};
            exp_fetch = {rpc_i[31:2], 2'b00};
            exp_mis   = (rpc_i[1:0] != 2'b00);
        end else begin
            exp_mis = 1'b0;
        end
        cyc++;
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic run_until_delivered(input string name, input int n, input int budget);
        int start;
        start = delivered;
        for (int i = 0; i < budget && (delivered - start) < n; i++)
            tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        total++;
        if ((delivered - start) < n) begin
            bad++;
            $display("FAIL %s timeout: delivered %0d want %0d", name, delivered - start, n);
        end
    endtask

    initial begin
        //            rst rdy rsv rdata redir rpc       drdy chk  rv  addr      dv  pc        instr mis
        tbl[0]  = '{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,  1'b1,1'b1, 1'b0,32'h000, 1'b0,32'h000,32'h0,1'b0};
        tbl[1]  = '{1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,  1'b1,1'b0, 1'b1,32'h000, 1'b0,32'h000,32'h0,1'b0};
        tbl[2]  = '{1'b0,1'b1,1'b1,W0,   1'b0,32'h0,  1'b1,1'b0, 1'b1,32'h004, 1'b0,32'h000,32'h0,1'b0};
        tbl[3]  = '{1'b0,1'b1,1'b1,W4,   1'b0,32'h0,  1'b1,1'b0, 1'b1,32'h008, 1'b1,32'h000,W0,   1'b0};
        tbl[4]  = '{1'b0,1'b1,1'b1,W8,   1'b0,32'h0,  1'b1,1'b0, 1'b1,32'h00C, 1'b1,32'h004,W4,   1'b0};
        tbl[5]  = '{1'b0,1'b1,1'b1,W12,  1'b1,32'h103,1'b1,1'b0, 1'b0,32'h010, 1'b1,32'h008,W8,   1'b0};
        tbl[6]  = '{1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,  1'b1,1'b0, 1'b1,32'h100, 1'b0,32'h000,32'h0,1'b1};
        tbl[7]  = '{1'b0,1'b1,1'b1,WA,   1'b0,32'h0,  1'b1,1'b0, 1'b1,32'h104, 1'b0,32'h000,32'h0,1'b0};
        tbl[8]  = '{1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,  1'b1,1'b0, 1'b1,32'h108, 1'b1,32'h100,WA,   1'b0};
        tbl[9]  = '{1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,  1'b1,1'b0, 1'b0,32'h10C, 1'b0,32'h000,32'h0,1'b0};
        tbl[10] = '{1'b1,1'b1,1'b0,32'h0,1'b0,32'h0,  1'b1,1'b0, 1'b0,32'h10C, 1'b0,32'h000,32'h0,1'b0};
        tbl[11] = '{1'b1,1'b1,1'b0,32'h0,1'b0,32'h0,  1'b1,1'b1, 1'b0,32'h000, 1'b0,32'h000,32'h0,1'b0};
        tbl[12] = '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,  1'b0,1'b0, 1'b1,32'h000, 1'b0,32'h000,32'h0,1'b0};
        tbl[13] = '{1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,  1'b0,1'b0, 1'b1,32'h000, 1'b0,32'h000,32'h0,1'b0};
        tbl[14] = '{1'b0,1'b0,1'b1,WB,   1'b0,32'h0,  1'b0,1'b0, 1'b1,32'h004, 1'b0,32'h000,32'h0,1'b0};
        tbl[15] = '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,  1'b0,1'b0, 1'b1,32'h004, 1'b1,32'h000,WB,   1'b0};
        tbl[16] = '{1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,  1'b0,1'b0, 1'b1,32'h004, 1'b1,32'h000,WB,   1'b0};
        tbl[17] = '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h008, 1'b1,32'h000,WB,   1'b0};

        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
        exp_pc         = RESET_PC;
        exp_fetch      = RESET_PC;
        last_hs_pc     = 32'h0;
        repeat (2) @(posedge clk);

        // Directed cycle table: reset state, fetch start, redirect to a
        // misaligned target with a response in the same cycle, mid-stream
        // reset, and the credit stall once the queue holds a word.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst            = tbl[i].rst;
            imem_req_ready = tbl[i].rdy;
            imem_rsp_valid = tbl[i].rsv;
            imem_rsp_data  = tbl[i].rdata;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            dec_ready      = tbl[i].drdy;
            #1;
            check($sformatf("row%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].e_rv});
            check($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].e_addr);
            check($sformatf("row%0d dec_valid", i), {31'b0, dec_valid}, {31'b0, tbl[i].e_dv});
            check($sformatf("row%0d misalign", i), {31'b0, misalign}, {31'b0, tbl[i].e_mis});
            if (tbl[i].chk || tbl[i].e_dv) begin
                check($sformatf("row%0d dec_pc", i), dec_pc, tbl[i].e_pc);
                check($sformatf("row%0d dec_instr", i), dec_instr, tbl[i].e_instr);
                check($sformatf("row%0d dec_pc_plus4", i), dec_pc_plus4, tbl[i].e_pc + 32'd4);
            end
        end

        // Steady state: 1-cycle memory, decode always ready -> pcs 0,4,8,12
        // handed over on four consecutive cycles starting 2 cycles after the
        // first request.
        lat_lo = 1; lat_hi = 1; rsp_pct = 100;
        do_reset();
        delivered = 0;
        repeat (6) tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("stream_count", delivered, 32'd4);
        check("stream_last_pc", last_hs_pc, 32'h0000_000C);

        // Decode stalled 6 cycles: only two fetches, then request held low.
        do_reset();
        accepts = 0;
        repeat (6) tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("stall_accepts", accepts, 32'd2);
        check("stall_req_valid", {31'b0, last_rv}, 32'd0);
        run_until_delivered("stall_release", 2, 10);
        check("stall_release_pc", last_hs_pc, 32'h4);

        // Redirect with two requests in flight: both late words dropped.
        lat_lo = 3; lat_hi = 3;
        do_reset();
        repeat (2) tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("redir2_outstanding", pend.size(), 32'd2);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
        run_until_delivered("redir2", 1, 30);
        check("redir2_pc", last_hs_pc, 32'h100);

        // Redirect in the same cycle as a response, one more still in flight.
        lat_lo = 2; lat_hi = 2;
        do_reset();
        repeat (2) tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("redir_rsp_setup", {31'b0, pend.size() == 2 && pend[0].due == cyc}, 32'd1);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
        run_until_delivered("redir_rsp", 2, 30);
        check("redir_rsp_pc", last_hs_pc, 32'h204);

        // PC wraps past the top of the address space.
        lat_lo = 1; lat_hi = 1;
        do_reset();
        tick(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        run_until_delivered("wrap", 3, 30);
        check("wrap_pc", last_hs_pc, 32'h0);

        // Reset with two requests outstanding.
        lat_lo = 3; lat_hi = 3;
        do_reset();
        repeat (2) tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("rst_mid_dec_valid", {31'b0, last_dv}, 32'd0);
        check("rst_mid_req_valid", {31'b0, last_rv}, 32'd0);
        run_until_delivered("rst_mid_restart", 2, 30);
        check("rst_mid_pc", last_hs_pc, RESET_PC + 32'd4);

        // Randomised traffic against the architectural model.
        lat_lo = 1; lat_hi = 3; rsp_pct = 80;
        do_reset();
        delivered = 0;
        for (int i = 0; i < 4000; i++) begin
            logic        r;
            logic        rd;
            logic [31:0] tgt;
            r   = ($urandom_range(999) < 4);
            rd  = !r && ($urandom_range(99) < 4);
            tgt = $urandom;
            tick(r, $urandom_range(99) < 75, $urandom_range(99) < 70, rd, tgt);
        end
        check("random_progress", {31'b0, delivered >= 400}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
